// File: rtl/pwm_pattern_sequencer.sv
// PWM pattern sequencer: a 16x8 pattern RAM loaded by the host, played back
// entry by entry as duty-cycle steps on a 4-bit-counter PWM output.
// Each entry holds duty in [3:0] and (repeat count - 1) in [7:4]; an entry
// lasts one fetch cycle plus (reps+1) PWM periods of 16 cycles each.
module pwm_pattern_sequencer #(
   parameter int CAPACITY = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wd,
   output logic [7:0] rd,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] len,
   input  logic       loop,
   output logic       out,
   output logic       busy,
   output logic [3:0] idx,
   output logic       done
);

   localparam int IW = $clog2(CAPACITY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Pattern storage; contents survive rst and start out all zero.
   logic [7:0] mem_reg [CAPACITY] = '{default: 8'h00};

   state_t        state_reg, state_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic [3:0]    rep_cnt_reg, rep_cnt_next;
   logic [3:0]    duty_reg, duty_next;
   logic [3:0]    reps_reg, reps_next;
   logic [IW-1:0] len_reg, len_next;
   logic          loop_reg, loop_next;
   logic          done_reg, done_next;
   logic [7:0]    fetch_word;
   logic          addr_hi_unused;

   // Only the low address bits select an entry; the rest alias.
   assign addr_hi_unused = ^addr[7:IW];

   assign rd   = mem_reg[addr[IW-1:0]];
   assign busy = (state_reg != IDLE);
   assign out  = (state_reg == RUN) && (cnt_reg < duty_reg);
   assign idx  = idx_reg;
   assign done = done_reg;

   // Host writes are locked out during playback so the pattern stays stable.
   always_ff @(posedge clk) begin
      if (we && !busy) begin
         mem_reg[addr[IW-1:0]] <= wd;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         cnt_reg     <= '0;
         rep_cnt_reg <= '0;
         duty_reg    <= '0;
         reps_reg    <= '0;
         len_reg     <= '0;
         loop_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         cnt_reg     <= cnt_next;
         rep_cnt_reg <= rep_cnt_next;
         duty_reg    <= duty_next;
         reps_reg    <= reps_next;
         len_reg     <= len_next;
         loop_reg    <= loop_next;
         done_reg    <= done_next;
      end
   end

   // Next-state logic: fetch an entry, play its periods, advance or finish.
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      cnt_next     = cnt_reg;
      rep_cnt_next = rep_cnt_reg;
      duty_next    = duty_reg;
      reps_next    = reps_reg;
      len_next     = len_reg;
      loop_next    = loop_reg;
      done_next    = 1'b0;
      fetch_word   = mem_reg[idx_reg];

      case (state_reg)
         IDLE: begin
            if (start) begin
               len_next   = len[IW-1:0];
               loop_next  = loop;
               idx_next   = '0;
               state_next = FETCH;
            end
         end
         FETCH: begin
            duty_next    = fetch_word[3:0];
            reps_next    = fetch_word[7:4];
            cnt_next     = '0;
            rep_cnt_next = '0;
            state_next   = RUN;
         end
         RUN: begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
               if (rep_cnt_reg != reps_reg) begin
                  rep_cnt_next = rep_cnt_reg + 4'd1;
               end else if (idx_reg != len_reg) begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = FETCH;
               end else if (loop_reg) begin
                  idx_next   = '0;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort wins over everything, including a start in the same cycle,
      // and leaves idx pointing at the entry that was interrupted.
      if (stop) begin
         state_next = IDLE;
         idx_next   = idx_reg;
         done_next  = 1'b0;
      end
   end

endmodule
